// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the time-shared ALU arbiter: ALU control codes and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_ADD       = 4'b0000;
    localparam logic [3:0] ALU_SUB       = 4'b0001;
    localparam logic [3:0] ALU_AND       = 4'b0010;
    localparam logic [3:0] ALU_OR        = 4'b0011;
    localparam logic [3:0] ALU_SLL       = 4'b0100;
    localparam logic [3:0] ALU_SLT       = 4'b0101;
    localparam logic [3:0] ALU_XOR       = 4'b0110;
    localparam logic [3:0] ALU_SRL       = 4'b0111;
    localparam logic [3:0] ALU_SRA       = 4'b1000;
    localparam logic [3:0] ALU_MAX_LEGAL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > ALU_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response, shared-ALU and status signals of the arbiter, bundled with both-side modports.
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic [3:0]        alu_ctrl;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_result;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
        output alu_ctrl, alu_a, alu_b, busy, grant_id
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
        input  alu_ctrl, alu_a, alu_b, busy, grant_id
    );
endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping NREQ-1 -> 0.
module alu_share_arbiter_rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters: round-robin grant, registered
// operands, one operation in flight (IDLE -> EXEC -> RESP).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    state_e          r_state, w_state_next;
    logic [IDW-1:0]  r_ptr, w_ptr_next;
    logic [IDW-1:0]  r_grant_id, w_grant_id_next;
    logic [3:0]      r_alu_ctrl, w_alu_ctrl_next;
    logic [W-1:0]    r_alu_a, w_alu_a_next;
    logic [W-1:0]    r_alu_b, w_alu_b_next;
    logic [NREQ-1:0] r_rsp_valid, w_rsp_valid_next;
    logic [W-1:0]    r_rsp_data, w_rsp_data_next;
    logic            r_rsp_zero, w_rsp_zero_next;
    logic            r_rsp_err, w_rsp_err_next;

    logic [NREQ-1:0] w_pick_grant;
    logic [IDW-1:0]  w_pick_idx;
    logic            w_pick_any;
    logic [3:0]      w_op;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_illegal;

    alu_share_arbiter_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IDW'(i)) begin
                w_op = bus.req_op[4*i +: 4];
                w_a  = bus.req_a[W*i +: W];
                w_b  = bus.req_b[W*i +: W];
            end
        end
    end

    assign w_illegal = op_illegal(r_alu_ctrl);

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_grant_id_next  = r_grant_id;
        w_alu_ctrl_next  = r_alu_ctrl;
        w_alu_a_next     = r_alu_a;
        w_alu_b_next     = r_alu_b;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_data_next  = r_rsp_data;
        w_rsp_zero_next  = r_rsp_zero;
        w_rsp_err_next   = r_rsp_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_alu_ctrl_next = w_op;
                    w_alu_a_next    = w_a;
                    w_alu_b_next    = w_b;
                    w_grant_id_next = w_pick_idx;
                    w_state_next    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal codes report a clean zero result rather than whatever the ALU emits.
                w_rsp_data_next  = w_illegal ? '0 : bus.alu_result;
                w_rsp_zero_next  = w_illegal || (bus.alu_result == '0);
                w_rsp_err_next   = w_illegal;
                w_rsp_valid_next = NREQ'(1) << r_grant_id;
                w_state_next     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[r_grant_id]) begin
                    w_rsp_valid_next = '0;
                    w_ptr_next       = (r_grant_id == IDW'(NREQ - 1)) ? '0
                                                                      : r_grant_id + IDW'(1);
                    w_state_next     = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_alu_ctrl  <= ALU_ADD;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_grant_id  <= w_grant_id_next;
            r_alu_ctrl  <= w_alu_ctrl_next;
            r_alu_a     <= w_alu_a_next;
            r_alu_b     <= w_alu_b_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_zero  <= w_rsp_zero_next;
            r_rsp_err   <= w_rsp_err_next;
        end
    end

    // Accept pulse is suppressed while reset is held so every output reads zero during reset.
    assign bus.req_ready = (r_state == ST_IDLE && rst_n) ? w_pick_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NREQ=4): directed vector table, multi-cycle corner
// sequences, and randomized transactions checked against a round-robin/ALU reference model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDW  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    alu_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    alu_share_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU; illegal codes return garbage the arbiter must mask.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLL: return a << b[4:0];
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_XOR: return a ^ b;
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return 32'($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);

    function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_op[4*r +: 4] = op;
        bus.req_a[32*r +: 32] = a;
        bus.req_b[32*r +: 32] = b;
    endtask

    // Full transaction from IDLE: accept, EXEC, RESP with 'stall' cycles of backpressure.
    task automatic do_txn(input string tag, input int w, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                          input logic ez, input logic ee, input int stall);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << w;
        #1;
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'(oh));
        chk({tag, " busy_idle"}, 64'(bus.busy), 64'(0));
        step();
        bus.req_valid[w] = 1'b0;
        chk({tag, " alu_ctrl"}, 64'(bus.alu_ctrl), 64'(op));
        chk({tag, " alu_a"}, 64'(bus.alu_a), 64'(a));
        chk({tag, " alu_b"}, 64'(bus.alu_b), 64'(b));
        chk({tag, " grant_id"}, 64'(bus.grant_id), 64'(w));
        chk({tag, " busy_exec"}, 64'(bus.busy), 64'(1));
        chk({tag, " rsp_valid_exec"}, 64'(bus.rsp_valid), 64'(0));
        step();
        chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
        chk({tag, " rsp_data"}, 64'(bus.rsp_data), 64'(ed));
        chk({tag, " rsp_zero"}, 64'(bus.rsp_zero), 64'(ez));
        chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(ee));
        chk({tag, " req_ready_resp"}, 64'(bus.req_ready), 64'(0));
        for (int s = 0; s < stall; s++) begin
            bus.rsp_ready = NREQ'($urandom) & ~oh;
            step();
            chk({tag, " stall_valid"}, 64'(bus.rsp_valid), 64'(oh));
            chk({tag, " stall_data"}, 64'(bus.rsp_data), 64'(ed));
            chk({tag, " stall_req_ready"}, 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = NREQ'($urandom) | oh;
        step();
        bus.rsp_ready = '0;
        chk({tag, " rsp_valid_done"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, " busy_done"}, 64'(bus.busy), 64'(0));
        m_ptr = (w + 1) % NREQ;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        step();
        step();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    typedef struct {
        int          req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] mask;
        logic [3:0]      rop[NREQ];
        logic [31:0]     ra[NREQ];
        logic [31:0]     rb[NREQ];
        logic [31:0]     ed;
        int              w;

        vecs[0]  = '{0, 4'b0001, 32'd10,         32'd3,         32'd7,         1'b0, 1'b0};
        vecs[1]  = '{1, 4'b0110, 32'h55,         32'h55,        32'h0,         1'b1, 1'b0};
        vecs[2]  = '{2, 4'b1011, 32'h1234,       32'h1,         32'h0,         1'b1, 1'b1};
        vecs[3]  = '{3, 4'b0101, 32'hFFFF_FFFF,  32'h1,         32'h1,         1'b0, 1'b0};
        vecs[4]  = '{0, 4'b1000, 32'h8000_0000,  32'd4,         32'hF800_0000, 1'b0, 1'b0};
        vecs[5]  = '{1, 4'b0100, 32'h1,          32'd31,        32'h8000_0000, 1'b0, 1'b0};
        vecs[6]  = '{2, 4'b0000, 32'hFFFF_FFFF,  32'h1,         32'h0,         1'b1, 1'b0};
        vecs[7]  = '{3, 4'b0111, 32'h8000_0000,  32'd31,        32'h1,         1'b0, 1'b0};
        vecs[8]  = '{0, 4'b1111, 32'h7,          32'h9,         32'h0,         1'b1, 1'b1};
        vecs[9]  = '{1, 4'b0010, 32'hF0F0,       32'hFF00,      32'hF000,      1'b0, 1'b0};
        vecs[10] = '{2, 4'b0011, 32'h0F00,       32'h00F0,      32'h0FF0,      1'b0, 1'b0};

        // Reset values, with a request already pending during reset.
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        bus.req_valid = 4'b0001;
        step();
        step();
        chk("rst req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("rst rsp_zero", 64'(bus.rsp_zero), 64'(0));
        chk("rst rsp_err", 64'(bus.rsp_err), 64'(0));
        chk("rst alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
        chk("rst alu_a", 64'(bus.alu_a), 64'(0));
        chk("rst alu_b", 64'(bus.alu_b), 64'(0));
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst grant_id", 64'(bus.grant_id), 64'(0));

        // Reset asserted mid-EXEC drops the op; it is reissued afterwards.
        rst_n = 1'b1;
        #1;
        chk("midrst req_ready", 64'(bus.req_ready), 64'(4'b0001));
        step();
        chk("midrst busy", 64'(bus.busy), 64'(1));
        chk("midrst alu_ctrl", 64'(bus.alu_ctrl), 64'(ALU_SUB));
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst busy_clr", 64'(bus.busy), 64'(0));
        chk("midrst alu_ctrl_clr", 64'(bus.alu_ctrl), 64'(0));
        chk("midrst alu_a_clr", 64'(bus.alu_a), 64'(0));
        chk("midrst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst req_ready_clr", 64'(bus.req_ready), 64'(0));
        step();
        chk("midrst no_rsp", 64'(bus.rsp_valid), 64'(0));
        rst_n = 1'b1;
        m_ptr = 0;
        do_txn("reissue", 0, ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 0);

        // Directed vector table, one requester at a time.
        for (int i = 0; i < 11; i++) begin
            set_req(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b);
            bus.req_valid = NREQ'(1) << vecs[i].req;
            do_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].data, vecs[i].zero, vecs[i].err, i % 3);
        end
        bus.req_valid = '0;

        // Contention: two requesters alternate every three cycles.
        do_reset();
        set_req(0, ALU_ADD, 32'd100, 32'd1);
        set_req(1, ALU_ADD, 32'd200, 32'd2);
        bus.req_valid = 4'b0011;
        bus.rsp_ready = 4'b1111;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("cont c%0d req_ready", c), 64'(bus.req_ready),
                (c % 3 == 0) ? (((c / 3) % 2 == 1) ? 64'h2 : 64'h1) : 64'h0);
            if (c % 3 == 1)
                chk($sformatf("cont c%0d grant_id", c), 64'(bus.grant_id), 64'((c / 3) % 2));
            if (c % 3 == 2) begin
                chk($sformatf("cont c%0d rsp_valid", c), 64'(bus.rsp_valid),
                    ((c / 3) % 2 == 1) ? 64'h2 : 64'h1);
                chk($sformatf("cont c%0d rsp_data", c), 64'(bus.rsp_data),
                    ((c / 3) % 2 == 1) ? 64'd202 : 64'd101);
            end
            step();
        end
        bus.rsp_ready = '0;
        m_ptr = 0;

        // Backpressure with a competing requester held valid.
        set_req(0, ALU_ADD, 32'd5, 32'd6);
        bus.req_valid = 4'b0011;
        do_txn("bp", 0, ALU_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 5);

        // Walk the pointer to 3, then check wrap-around priority.
        do_txn("wrap_r1", 1, ALU_ADD, 32'd200, 32'd2, 32'd202, 1'b0, 1'b0, 0);
        set_req(2, ALU_XOR, 32'hFF, 32'h0F);
        bus.req_valid = 4'b0100;
        do_txn("wrap_r2", 2, ALU_XOR, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0, 0);
        set_req(3, ALU_OR, 32'd1, 32'd2);
        set_req(0, ALU_SUB, 32'd9, 32'd4);
        bus.req_valid = 4'b1001;
        do_txn("wrap_r3", 3, ALU_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 0);
        do_txn("wrap_r0", 0, ALU_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1);
        bus.req_valid = '0;

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                rop[i] = 4'($urandom_range(0, 15));
                ra[i]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                rb[i]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                set_req(i, rop[i], ra[i], rb[i]);
            end
            bus.req_valid = mask;
            w = pick(mask, m_ptr);
            ed = (rop[w] > 4'd8) ? 32'd0 : alu_f(rop[w], ra[w], rb[w]);
            do_txn($sformatf("rnd%0d", n), w, rop[w], ra[w], rb[w], ed, ed == 32'd0,
                   rop[w] > 4'd8, $urandom_range(0, 3));
            bus.req_valid = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
